// File: rtl/sc_output_timing_gen_if.sv
// Output-side video bus of the scan converter: line-buffer read address plus
// the delayed timing and active-area position that accompany it.
interface sc_output_timing_gen_if #(
  parameter int unsigned H_W    = 12,
  parameter int unsigned V_W    = 11,
  parameter int unsigned LB_Y_W = 6
);
  logic [H_W-1:0]    lb_xaddr_o;
  logic [LB_Y_W-1:0] lb_yaddr_o;
  logic              HSYNC_o;
  logic              VSYNC_o;
  logic              DE_o;
  logic [H_W-1:0]    xpos_o;
  logic [V_W-1:0]    ypos_o;

  modport master (
    output lb_xaddr_o, lb_yaddr_o, HSYNC_o, VSYNC_o, DE_o, xpos_o, ypos_o
  );
  modport slave (
    input  lb_xaddr_o, lb_yaddr_o, HSYNC_o, VSYNC_o, DE_o, xpos_o, ypos_o
  );
endinterface

// File: rtl/sc_output_timing_gen.sv
// Output pixel-clock timing generator: H/V counters, sync/DE, frame lock to the
// input frame strobe, and line-buffer read addressing with repeat/skip/bob.
module sc_output_timing_gen #(
  parameter int unsigned H_W              = 12,
  parameter int unsigned V_W              = 11,
  parameter int unsigned NUM_LINE_BUFFERS = 40,
  parameter int unsigned LB_Y_W           = 6,
  parameter int unsigned RPT_W            = 3,
  parameter int unsigned PP_DELAY         = 3,
  parameter int unsigned LOCK_FRAMES      = 4
) (
  input  logic                PCLK_i,
  input  logic                reset,
  input  logic                frame_change_i,
  input  logic                interlaced_in_i,
  input  logic [H_W-1:0]      h_total,
  input  logic [H_W-1:0]      h_active,
  input  logic [H_W-1:0]      h_backporch,
  input  logic [H_W-1:0]      h_synclen,
  input  logic [V_W-1:0]      v_total,
  input  logic [V_W-1:0]      v_active,
  input  logic [V_W-1:0]      v_backporch,
  input  logic [V_W-1:0]      v_synclen,
  input  logic [V_W-1:0]      v_startline,
  input  logic                v_interlaced,
  input  logic                hsync_pol,
  input  logic                vsync_pol,
  input  logic [H_W-1:0]      x_start_lb,
  input  logic signed [6:0]   y_start_lb,
  input  logic signed [H_W:0] x_offset,
  input  logic [RPT_W-1:0]    x_rpt,
  input  logic [RPT_W-1:0]    y_rpt,
  input  logic                lm_deint_mode,
  output logic                src_fid_o,
  output logic                dst_fid_o,
  output logic                resync_strobe_o,
  output logic                locked_o,
  sc_output_timing_gen_if.master vid
);

  localparam int unsigned LCK_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [LCK_W-1:0] LOCK_MAX = LCK_W'(LOCK_FRAMES);
  localparam logic signed [7:0] NLB = 8'(NUM_LINE_BUFFERS);

  logic [H_W-1:0]   h_cnt, h_half, h_de_start, h_de_end, x_thr;
  logic [V_W-1:0]   v_cnt, vt, vs_prev, v_de_start, v_de_end;
  logic             fc_s1, fc_s2, fc_s3, fc_rise;
  logic [LCK_W-1:0] lock_cnt;
  logic             h_wrap, v_wrap, aligned;
  logic             hs0, vs0, de0, line_start, first_line, skip, bob;
  logic [RPT_W:0]   y_rpt_p1;

  logic [H_W-1:0]    lb_x;
  logic signed [6:0] lb_y;
  logic signed [7:0] ly_sum, ly_adv, ly_mod;
  logic [RPT_W-1:0]  x_ctr, y_ctr;

  logic [2:0]     tp [PP_DELAY];
  logic [H_W-1:0] xp [PP_DELAY];
  logic [V_W-1:0] yp [PP_DELAY];

  always_comb begin
    vt       = v_interlaced ? (v_total >> 1) : v_total;
    h_half   = h_total >> 1;
    h_wrap   = (h_cnt == h_total - 1'b1);
    v_wrap   = (v_interlaced && dst_fid_o) ? (v_cnt == vt) : (v_cnt == vt - 1'b1);
    vs_prev  = (v_startline == '0) ? vt - 1'b1 : v_startline - 1'b1;
    aligned  = (v_cnt == vs_prev) || (v_cnt == v_startline);
    fc_rise  = fc_s2 & ~fc_s3;
    locked_o = (lock_cnt == LOCK_MAX);
  end

  always_ff @(posedge PCLK_i or posedge reset) begin
    if (reset) begin
      fc_s1           <= 1'b0;
      fc_s2           <= 1'b0;
      fc_s3           <= 1'b0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      src_fid_o       <= 1'b1;
      dst_fid_o       <= 1'b1;
      resync_strobe_o <= 1'b0;
      lock_cnt        <= '0;
    end else begin
      fc_s1 <= frame_change_i;
      fc_s2 <= fc_s1;
      fc_s3 <= fc_s2;
      // A misaligned strobe overrides whatever wrap would have happened this cycle
      if (fc_rise && !aligned) begin
        h_cnt           <= '0;
        v_cnt           <= v_startline;
        src_fid_o       <= ~interlaced_in_i | (v_startline < (vt >> 1));
        dst_fid_o       <= ~v_interlaced | (v_startline < (vt >> 1));
        resync_strobe_o <= 1'b1;
        lock_cnt        <= '0;
      end else begin
        if (fc_rise && (lock_cnt != LOCK_MAX))
          lock_cnt <= lock_cnt + 1'b1;
        if (h_wrap) begin
          h_cnt <= '0;
          if (v_wrap) begin
            v_cnt           <= '0;
            src_fid_o       <= interlaced_in_i ? ~src_fid_o : 1'b1;
            dst_fid_o       <= v_interlaced ? ~dst_fid_o : 1'b1;
            resync_strobe_o <= 1'b0;
          end else begin
            v_cnt <= v_cnt + 1'b1;
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    h_de_start = h_synclen + h_backporch;
    h_de_end   = h_de_start + h_active;
    v_de_start = v_synclen + v_backporch;
    v_de_end   = v_de_start + v_active;
    hs0        = (h_cnt < h_synclen);
    if (dst_fid_o)
      vs0 = (v_cnt < v_synclen) || ((v_cnt == vt) && (h_cnt >= h_half));
    else
      vs0 = (v_cnt < v_synclen - 1'b1) ||
            ((v_cnt == v_synclen - 1'b1) && (h_cnt < h_half));
    de0 = (h_cnt >= h_de_start) && (h_cnt < h_de_end) &&
          (v_cnt >= v_de_start) && (v_cnt < v_de_end);
    line_start = (h_cnt == h_de_start);
    first_line = (v_cnt == v_de_start);
    skip       = &y_rpt;
    bob        = ~lm_deint_mode && (y_rpt != '0) && ~v_interlaced && ~src_fid_o;
    x_thr      = x_offset[H_W] ? '0 : x_offset[H_W-1:0];
    y_rpt_p1   = {1'b0, y_rpt} + 1'b1;
    ly_sum     = 8'(lb_y) + (skip ? 8'sd2 : 8'sd1);
    ly_adv     = (ly_sum >= NLB) ? ly_sum - NLB : ly_sum;
    // lb_y may sit at -1 after a bob start; fold it into the buffer range
    if (lb_y < 0)
      ly_mod = 8'(lb_y) + NLB;
    else if (8'(lb_y) >= NLB)
      ly_mod = 8'(lb_y) - NLB;
    else
      ly_mod = 8'(lb_y);
  end

  always_ff @(posedge PCLK_i or posedge reset) begin
    if (reset) begin
      lb_x  <= '0;
      lb_y  <= '0;
      x_ctr <= '0;
      y_ctr <= '0;
      for (int unsigned i = 0; i < PP_DELAY; i++) begin
        tp[i] <= '0;
        xp[i] <= '0;
        yp[i] <= '0;
      end
    end else begin
      if (line_start) begin
        xp[0] <= '0;
        lb_x  <= x_start_lb;
        x_ctr <= '0;
        if (first_line) begin
          yp[0] <= '0;
          if (bob) begin
            lb_y  <= y_start_lb - 7'sd1;
            y_ctr <= y_rpt_p1[RPT_W:1];
          end else begin
            lb_y  <= y_start_lb + {6'd0, skip & ~dst_fid_o};
            y_ctr <= '0;
          end
        end else begin
          if (yp[0] < v_active)
            yp[0] <= yp[0] + 1'b1;
          if ((y_ctr == y_rpt) || skip) begin
            lb_y  <= ly_adv[6:0];
            y_ctr <= '0;
          end else begin
            y_ctr <= y_ctr + 1'b1;
          end
        end
      end else begin
        if (xp[0] < h_active)
          xp[0] <= xp[0] + 1'b1;
        if (xp[0] >= x_thr) begin
          if (x_ctr == x_rpt) begin
            lb_x  <= lb_x + 1'b1;
            x_ctr <= '0;
          end else begin
            x_ctr <= x_ctr + 1'b1;
          end
        end
      end
      tp[0] <= {hs0, vs0, de0};
      for (int unsigned i = 1; i < PP_DELAY; i++) begin
        tp[i] <= tp[i-1];
        xp[i] <= xp[i-1];
        yp[i] <= yp[i-1];
      end
    end
  end

  always_comb begin
    vid.lb_xaddr_o = lb_x;
    vid.lb_yaddr_o = ly_mod[LB_Y_W-1:0];
    vid.HSYNC_o    = tp[PP_DELAY-1][2] ? hsync_pol : ~hsync_pol;
    vid.VSYNC_o    = tp[PP_DELAY-1][1] ? vsync_pol : ~vsync_pol;
    vid.DE_o       = tp[PP_DELAY-1][0];
    vid.xpos_o     = xp[PP_DELAY-1];
    vid.ypos_o     = yp[PP_DELAY-1];
  end

endmodule

// File: tb/tb_sc_output_timing_gen.sv
// Directed bench for sc_output_timing_gen: 10x6 test timing, address repeat/skip/bob,
// resync, frame lock and asynchronous reset.
module tb_sc_output_timing_gen;
  logic              PCLK_i = 1'b0;
  logic              reset = 1'b1;
  logic              frame_change_i = 1'b0;
  logic              interlaced_in_i;
  logic [11:0]       h_total, h_active, h_backporch, h_synclen;
  logic [10:0]       v_total, v_active, v_backporch, v_synclen, v_startline;
  logic              v_interlaced, hsync_pol, vsync_pol;
  logic [11:0]       x_start_lb;
  logic signed [6:0] y_start_lb;
  logic signed [12:0] x_offset;
  logic [2:0]        x_rpt, y_rpt;
  logic              lm_deint_mode;
  logic              src_fid_o, dst_fid_o, resync_strobe_o, locked_o;

  sc_output_timing_gen_if #(.H_W(12), .V_W(11), .LB_Y_W(6)) vid ();

  sc_output_timing_gen #(
    .H_W(12), .V_W(11), .NUM_LINE_BUFFERS(40), .LB_Y_W(6),
    .RPT_W(3), .PP_DELAY(3), .LOCK_FRAMES(4)
  ) dut (
    .PCLK_i(PCLK_i), .reset(reset), .frame_change_i(frame_change_i),
    .interlaced_in_i(interlaced_in_i),
    .h_total(h_total), .h_active(h_active), .h_backporch(h_backporch), .h_synclen(h_synclen),
    .v_total(v_total), .v_active(v_active), .v_backporch(v_backporch), .v_synclen(v_synclen),
    .v_startline(v_startline), .v_interlaced(v_interlaced),
    .hsync_pol(hsync_pol), .vsync_pol(vsync_pol),
    .x_start_lb(x_start_lb), .y_start_lb(y_start_lb), .x_offset(x_offset),
    .x_rpt(x_rpt), .y_rpt(y_rpt), .lm_deint_mode(lm_deint_mode),
    .src_fid_o(src_fid_o), .dst_fid_o(dst_fid_o),
    .resync_strobe_o(resync_strobe_o), .locked_o(locked_o),
    .vid(vid)
  );

  always #5 PCLK_i = ~PCLK_i;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask

  task automatic cfg_base();
    interlaced_in_i = 1'b0;
    h_total = 12'd10; h_active = 12'd4; h_backporch = 12'd2; h_synclen = 12'd2;
    v_total = 11'd6;  v_active = 11'd2; v_backporch = 11'd1; v_synclen = 11'd1;
    v_startline = 11'd0; v_interlaced = 1'b0;
    hsync_pol = 1'b1; vsync_pol = 1'b1;
    x_start_lb = 12'd5; y_start_lb = 7'sd38; x_offset = 13'sd0;
    x_rpt = 3'd1; y_rpt = 3'd0; lm_deint_mode = 1'b1;
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    frame_change_i = 1'b0;
    cfg_base();
  endtask

  // Releases reset at a falling edge; cycle 0 is the state right after release.
  task automatic release_reset();
    repeat (2) @(negedge PCLK_i);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) begin
      @(negedge PCLK_i);
      cyc++;
    end
  endtask

  initial begin
    int m, h, v, p, hp, vp;
    bit e_de;

    // Progressive 10x6 timing, x repeat 1, line-buffer wrap from 39
    hold_reset();
    release_reset();
    chk("rst_locked", locked_o, 0);
    chk("rst_strobe", resync_strobe_o, 0);
    chk("rst_dst_fid", dst_fid_o, 1);
    chk("rst_src_fid", src_fid_o, 1);
    chk("rst_lbx", vid.lb_xaddr_o, 0);
    for (int n = 0; n <= 87; n++) begin
      run_to(n);
      if (n >= 3) begin
        m = n - 3; h = m % 10; v = (m / 10) % 6;
        e_de = (h >= 4) && (h < 8) && (v >= 2) && (v < 4);
        chk("de", vid.DE_o, e_de);
        chk("hsync", vid.HSYNC_o, h < 2);
        chk("vsync", vid.VSYNC_o, v == 0);
        if (e_de) begin
          chk("xpos", vid.xpos_o, h - 4);
          chk("ypos", vid.ypos_o, v - 2);
        end
      end else begin
        chk("de_pipe0", vid.DE_o, 0);
        chk("hs_pipe0", vid.HSYNC_o, 0);
      end
      if (n >= 1) begin
        p = n - 1; hp = p % 10; vp = (p / 10) % 6;
        if (hp >= 4 && hp < 8 && vp >= 2 && vp < 4)
          chk("lb_x", vid.lb_xaddr_o, 5 + (hp - 4) / 2);
        if (hp == 4 && p >= 24)
          chk("lb_y", vid.lb_yaddr_o, (38 + (vp + 4) % 6) % 40);
      end
    end
    // Mid-line asynchronous reset while DE_o is high
    #2 reset = 1'b1;
    #1;
    chk("arst_de", vid.DE_o, 0);
    chk("arst_hs", vid.HSYNC_o, 0);
    chk("arst_vs", vid.VSYNC_o, 0);
    chk("arst_lbx", vid.lb_xaddr_o, 0);
    chk("arst_lby", vid.lb_yaddr_o, 0);
    chk("arst_xpos", vid.xpos_o, 0);
    chk("arst_ypos", vid.ypos_o, 0);
    chk("arst_fid", dst_fid_o, 1);

    // Interlaced output, line skip: odd field 70 cycles, even field starts +1
    hold_reset();
    v_total = 11'd12; v_interlaced = 1'b1; y_rpt = 3'd7; y_start_lb = 7'sd0;
    release_reset();
    run_to(20);  chk("skip_fid_odd", dst_fid_o, 1);
    run_to(25);  chk("skip_odd_l0", vid.lb_yaddr_o, 0);
    run_to(35);  chk("skip_odd_l1", vid.lb_yaddr_o, 2);
    run_to(45);  chk("skip_odd_l2", vid.lb_yaddr_o, 4);
    run_to(67);  chk("ivs_pre", vid.VSYNC_o, 0);
    run_to(70);  chk("ivs_half", vid.VSYNC_o, 1);
    run_to(77);  chk("ivs_even", vid.VSYNC_o, 1);
    run_to(78);  chk("ivs_end", vid.VSYNC_o, 0);
    run_to(80);  chk("skip_fid_even", dst_fid_o, 0);
    run_to(95);  chk("skip_even_l0", vid.lb_yaddr_o, 1);
    run_to(105); chk("skip_even_l1", vid.lb_yaddr_o, 3);
    run_to(115); chk("skip_even_l2", vid.lb_yaddr_o, 5);

    // Resync and lock, active-low syncs; edge sampled at v=3 resyncs at cycle 34
    hold_reset();
    hsync_pol = 1'b0; vsync_pol = 1'b0;
    release_reset();
    chk("pol_hs_idle", vid.HSYNC_o, 1);
    chk("pol_vs_idle", vid.VSYNC_o, 1);
    run_to(31); frame_change_i = 1'b1;
    run_to(33); chk("rs_before", resync_strobe_o, 0);
    run_to(34); chk("rs_set", resync_strobe_o, 1);
    run_to(37); chk("rs_hs_active", vid.HSYNC_o, 0);
    run_to(39); chk("rs_hs_idle", vid.HSYNC_o, 1);
    run_to(40); frame_change_i = 1'b0;
    run_to(60); chk("rs_de_lo", vid.DE_o, 0);
    run_to(61); chk("rs_de_hi", vid.DE_o, 1);
    run_to(93); chk("rs_hold", resync_strobe_o, 1);
    run_to(94); chk("rs_clear", resync_strobe_o, 0);
    for (int j = 1; j <= 4; j++) begin
      run_to(34 + 60 * j + 2); frame_change_i = 1'b1;
      if (j == 4) begin
        run_to(278); chk("lock_pre", locked_o, 0);
        run_to(279); chk("lock_set", locked_o, 1);
      end
      run_to(34 + 60 * j + 20); frame_change_i = 1'b0;
      if (j == 3) chk("lock_3", locked_o, 0);
    end
    run_to(364); frame_change_i = 1'b1;
    run_to(366); chk("lock_hold", locked_o, 1);
    run_to(367); chk("lock_lost", locked_o, 0);
    chk("lock_rs", resync_strobe_o, 1);

    // Bob deinterlace: even source field starts at y_start_lb-1 (wraps to 39)
    hold_reset();
    interlaced_in_i = 1'b1; lm_deint_mode = 1'b0; y_rpt = 3'd1; y_start_lb = 7'sd0;
    release_reset();
    run_to(25); chk("bob_odd_l0", vid.lb_yaddr_o, 0);
    run_to(35); chk("bob_odd_l1", vid.lb_yaddr_o, 0);
    run_to(45); chk("bob_odd_l2", vid.lb_yaddr_o, 1);
    run_to(65); chk("bob_src_fid", src_fid_o, 0);
    run_to(85); chk("bob_even_l0", vid.lb_yaddr_o, 39);
    run_to(95); chk("bob_even_l1", vid.lb_yaddr_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
